// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: serial double-dabble binary-to-BCD converter
// feeding a time-multiplexed 7-segment digit scanner.
module seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int VAL_W    = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [VAL_W-1:0]  value,
    output logic              busy,
    output logic              overflow,
    output logic [5:0]        digit_num,
    output logic [DIGITS-1:0] anode
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int STEP_W = $clog2(VAL_W + 1);
    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(DIGITS);

    localparam logic [STEP_W-1:0] STEPS    = STEP_W'(VAL_W);
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(SCAN_DIV - 1);
    localparam logic [VAL_W-1:0]  MAX_DISP = VAL_W'(9999);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [VAL_W-1:0]    shreg;
    logic [BCD_W-1:0]    scratch;
    logic [BCD_W-1:0]    adj;
    logic [STEP_W-1:0]   step;
    logic                ovf_flag;
    logic [3:0]          digit [DIGITS];
    logic [DIV_W-1:0]    div;
    logic [IDX_W-1:0]    idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (load) begin
                    state_nxt = CONVERT;
                end
            end
            CONVERT: begin
                if (step == STEP_W'(1)) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Add-3 correction on each nibble, applied before the shift.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            scratch  <= '0;
            step     <= '0;
            ovf_flag <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                digit[i] <= 4'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg    <= value;
                        scratch  <= '0;
                        ovf_flag <= (value > MAX_DISP);
                        step     <= STEPS;
                    end
                end
                CONVERT: begin
                    {scratch, shreg} <= {adj, shreg} << 1;
                    step             <= step - STEP_W'(1);
                end
                COMMIT: begin
                    overflow <= ovf_flag;
                    for (int i = 0; i < DIGITS; i++) begin
                        digit[i] <= ovf_flag ? 4'd10 : scratch[4*i +: 4];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_MAX) begin
            div <= '0;
            idx <= idx + IDX_W'(1);
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Outputs derive from registers updated on the same edge,
    // so a commit and a scan advance appear together.
    assign digit_num = {2'b00, digit[idx]};
    assign anode     = ~(DIGITS'(1) << idx);

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl
// with a short scan divider.
module tb_seg_scan_ctrl;

    localparam int SD = 4;

    typedef struct packed {
        logic [15:0] d;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [13:0] value = '0;
    logic        busy;
    logic        overflow;
    logic [5:0]  digit_num;
    logic [3:0]  anode;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .DIGITS(4),
        .VAL_W(14),
        .SCAN_DIV(SD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .value(value),
        .busy(busy),
        .overflow(overflow),
        .digit_num(digit_num),
        .anode(anode)
    );

    function automatic exp_t model(input int v);
        exp_t e;
        if (v > 9999) begin
            e.d   = 16'hAAAA;
            e.ovf = 1'b1;
        end else begin
            e.ovf = 1'b0;
            e.d   = {4'(v / 1000), 4'((v / 100) % 10),
                     4'((v / 10) % 10), 4'(v % 10)};
        end
        return e;
    endfunction

    function automatic int pos_of(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic do_load(input int v);
        @(negedge clk);
        value = 14'(v);
        load  = 1'b1;
        sbq.push_back(model(v));
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic read_display(output logic [15:0] d, output bit ok);
        logic [3:0] want;
        int n;
        ok = 1'b1;
        d  = '0;
        for (int i = 0; i < 4; i++) begin
            want = ~(4'b0001 << i);
            n = 0;
            while (anode !== want && n < 8 * SD) begin
                @(negedge clk);
                n++;
            end
            if (anode !== want) ok = 1'b0;
            else d[4*i +: 4] = digit_num[3:0];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (anode !== 4'b1110) begin
            miscompares++;
            $display("FAIL reset_anode got %b want 1110", anode);
        end
        vectors++;
        if (digit_num !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_digit got %0d want 0", digit_num);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ovf got %b want 0", overflow);
        end
    endtask

    task automatic test_basic();
        int cnt;
        exp_t e;
        logic [15:0] d;
        bit ok;
        @(negedge clk);
        value = 14'd1234;
        load  = 1'b1;
        sbq.push_back(model(1234));
        @(negedge clk);
        load = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        vectors++;
        if (cnt !== 15) begin
            miscompares++;
            $display("FAIL basic_busy_len got %0d want 15", cnt);
        end
        e = sbq.pop_front();
        read_display(d, ok);
        vectors++;
        if (!ok || d !== e.d) begin
            miscompares++;
            $display("FAIL basic_digits got %h ok=%0d want %h", d, ok, e.d);
        end
        vectors++;
        if (overflow !== e.ovf) begin
            miscompares++;
            $display("FAIL basic_ovf got %b want %b", overflow, e.ovf);
        end
    endtask

    task automatic test_boundary();
        int vals[4] = '{9999, 10000, 7, 0};
        int cyc;
        exp_t e;
        logic [15:0] d;
        bit ok;
        foreach (vals[k]) begin
            do_load(vals[k]);
            wait_idle(cyc);
            e = sbq.pop_front();
            read_display(d, ok);
            vectors++;
            if (!ok || d !== e.d) begin
                miscompares++;
                $display("FAIL bound_%0d_digits got %h ok=%0d want %h",
                         vals[k], d, ok, e.d);
            end
            vectors++;
            if (overflow !== e.ovf) begin
                miscompares++;
                $display("FAIL bound_%0d_ovf got %b want %b",
                         vals[k], overflow, e.ovf);
            end
        end
    endtask

    task automatic test_busy();
        int cyc;
        exp_t e;
        logic [15:0] d;
        bit ok;
        @(negedge clk);
        value = 14'd42;
        load  = 1'b1;
        sbq.push_back(model(42));
        @(negedge clk);
        for (int j = 0; j <= 16; j++) begin
            load  = (j == 4 || j == 13);
            value = load ? 14'd999 : 14'd42;
            if (j == 14) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_k14 got %b want 1", busy);
                end
            end
            if (j == 16) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy_k16 got %b want 0", busy);
                end
            end
            @(negedge clk);
        end
        load = 1'b0;
        e = sbq.pop_front();
        read_display(d, ok);
        vectors++;
        if (!ok || d !== e.d) begin
            miscompares++;
            $display("FAIL busy_hold got %h ok=%0d want %h", d, ok, e.d);
        end
        do_load(999);
        wait_idle(cyc);
        e = sbq.pop_front();
        read_display(d, ok);
        vectors++;
        if (!ok || d !== e.d) begin
            miscompares++;
            $display("FAIL busy_after got %h ok=%0d want %h", d, ok, e.d);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        exp_t e;
        logic [15:0] d;
        bit ok;
        do_load(12000);
        wait_idle(cnt);
        e = sbq.pop_front();
        vectors++;
        if (overflow !== e.ovf) begin
            miscompares++;
            $display("FAIL rmid_pre_ovf got %b want %b", overflow, e.ovf);
        end
        @(negedge clk);
        value = 14'd5678;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int j = 0; j < 7; j++) begin
            rst = (j == 6);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_busy got %b want 0", busy);
        end
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_ovf got %b want 0", overflow);
        end
        read_display(d, ok);
        vectors++;
        if (!ok || d !== 16'h0000) begin
            miscompares++;
            $display("FAIL rmid_digits got %h ok=%0d want 0000", d, ok);
        end
        @(negedge clk);
        value = 14'd5678;
        load  = 1'b1;
        sbq.push_back(model(5678));
        @(negedge clk);
        load = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        vectors++;
        if (cnt !== 15) begin
            miscompares++;
            $display("FAIL rmid_busy_len got %0d want 15", cnt);
        end
        e = sbq.pop_front();
        read_display(d, ok);
        vectors++;
        if (!ok || d !== e.d) begin
            miscompares++;
            $display("FAIL rmid_reload got %h ok=%0d want %h", d, ok, e.d);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int p;
        exp_t e;
        logic [15:0] d;
        bit ok;
        @(negedge clk);
        value = 14'd321;
        load  = 1'b1;
        sbq.push_back(model(321));
        sbq.push_back(model(8765));
        @(negedge clk);
        load = 1'b0;
        repeat (15) @(negedge clk);
        e = sbq.pop_front();
        p = pos_of(anode);
        vectors++;
        if (busy !== 1'b0 || p < 0 || digit_num !== {2'b00, e.d[4*p +: 4]}) begin
            miscompares++;
            $display("FAIL b2b_first got num=%0d busy=%b anode=%b want %h",
                     digit_num, busy, anode, e.d);
        end
        value = 14'd8765;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept got %b want 1", busy);
        end
        wait_idle(cyc);
        e = sbq.pop_front();
        read_display(d, ok);
        vectors++;
        if (!ok || d !== e.d) begin
            miscompares++;
            $display("FAIL b2b_second got %h ok=%0d want %h", d, ok, e.d);
        end
    endtask

    task automatic test_scan();
        logic [3:0] prev;
        int run;
        int cyc;
        exp_t e;
        logic [15:0] d;
        bit ok;
        do_load(4321);
        prev = anode;
        run = 0;
        while (anode === prev && run < 4 * SD) begin
            @(negedge clk);
            run++;
        end
        for (int r = 0; r < 12; r++) begin
            prev = anode;
            run = 0;
            while (anode === prev && run < 4 * SD) begin
                @(negedge clk);
                run++;
            end
            vectors++;
            if (run !== SD) begin
                miscompares++;
                $display("FAIL scan_period_%0d got %0d want %0d", r, run, SD);
            end
            vectors++;
            if (pos_of(prev) < 0 || pos_of(anode) !== (pos_of(prev) + 1) % 4) begin
                miscompares++;
                $display("FAIL scan_order_%0d got %b after %b", r, anode, prev);
            end
        end
        wait_idle(cyc);
        e = sbq.pop_front();
        read_display(d, ok);
        vectors++;
        if (!ok || d !== e.d) begin
            miscompares++;
            $display("FAIL scan_digits got %h ok=%0d want %h", d, ok, e.d);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        test_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
